// File: rtl/demux_buf_pkg.sv
// ============================================================================
// Module      : demux_buf_pkg
// Description : Shared routing type and width helpers for the buffered demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_buf_pkg;

    // How an accepted input word is disposed of
    typedef enum logic [1:0] {
        ROUTE_UNICAST = 2'd0,
        ROUTE_DROP    = 2'd1,
        ROUTE_BCAST   = 2'd2
    } route_e;

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int sel_w(input int num);
        return (num < 2) ? 1 : $clog2(num);
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_buf_fifo.sv
// ============================================================================
// Module      : demux_buf_fifo
// Description : Per-channel synchronous FIFO with a registered, zeroed-when-
//               empty head word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_buf_fifo
    import demux_buf_pkg::*;
#(
    parameter int DATA_BW = 8,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [DATA_BW-1:0]        i_wdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output logic [DATA_BW-1:0]        o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_BW-1:0] r_mem_q [DEPTH];
    logic [DATA_BW-1:0] w_mem_d [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [PTR_W-1:0]   w_rd_next;
    logic [CNT_W-1:0]   r_count_q, w_count_d;
    logic [DATA_BW-1:0] r_head_q, w_head_d;
    logic               w_push, w_pop;

    assign o_full  = (r_count_q == CNT_W'(DEPTH));
    assign o_empty = (r_count_q == '0);
    assign o_count = r_count_q;
    assign o_head  = r_head_q;

    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;
    assign w_rd_next = r_rd_ptr_q + PTR_W'(1);

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        w_head_d   = r_head_q;

        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = i_wdata;
            w_wr_ptr_d          = r_wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = w_rd_next;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + CNT_W'(1);
            2'b01:   w_count_d = r_count_q - CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase

        // Head tracks the word at the read pointer so out_data is a flop output
        if (w_pop) begin
            if (r_count_q > CNT_W'(1)) begin
                w_head_d = r_mem_q[w_rd_next];
            end else if (w_push) begin
                w_head_d = i_wdata;
            end else begin
                w_head_d = '0;
            end
        end else if (o_empty && w_push) begin
            w_head_d = i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem_q[k] <= '0;
            end
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_head_q   <= '0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_head_q   <= w_head_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_buf.sv
// ============================================================================
// Module      : demux_buf
// Description : Handshaked 1-to-NUM_DATA demultiplexer with a DEPTH-entry FIFO
//               per output channel. Define DEMUX_BCAST_EN to add in_bcast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_buf
    import demux_buf_pkg::*;
#(
    parameter int NUM_DATA = 4,
    parameter int DATA_BW  = 8,
    parameter int DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_BW-1:0]                 in_data,
`ifdef DEMUX_BCAST_EN
    input  logic                               in_bcast,
`endif
    input  logic [sel_w(NUM_DATA)-1:0]         sel,
    output logic [NUM_DATA-1:0]                out_valid,
    input  logic [NUM_DATA-1:0]                out_ready,
    output logic [DATA_BW*NUM_DATA-1:0]        out_data,
    output logic [cnt_w(DEPTH)*NUM_DATA-1:0]   out_count,
    output logic                               sel_err
);

    localparam int SEL_W = sel_w(NUM_DATA);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [NUM_DATA-1:0] w_full;
    logic [NUM_DATA-1:0] w_empty;
    logic [NUM_DATA-1:0] w_push;
    logic [NUM_DATA-1:0] w_pop;
    logic                w_bcast;
    logic                w_sel_in_range;
    logic                w_sel_full;
    logic                w_accept;
    route_e              w_route;
    logic                r_sel_err_q, w_sel_err_d;

`ifdef DEMUX_BCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    assign w_sel_in_range = ({1'b0, sel} < (SEL_W + 1)'(NUM_DATA));

    always_comb begin
        w_sel_full = 1'b0;
        for (int i = 0; i < NUM_DATA; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_full = w_full[i];
            end
        end

        if (w_bcast) begin
            w_route = ROUTE_BCAST;
        end else if (w_sel_in_range) begin
            w_route = ROUTE_UNICAST;
        end else begin
            w_route = ROUTE_DROP;
        end

        // Depends only on buffer state, never on out_ready
        case (w_route)
            ROUTE_BCAST:   in_ready = ~|w_full;
            ROUTE_UNICAST: in_ready = ~w_sel_full;
            ROUTE_DROP:    in_ready = 1'b1;
            default:       in_ready = 1'b0;
        endcase

        w_accept    = in_valid & in_ready;
        w_sel_err_d = w_accept & (w_route == ROUTE_DROP);

        for (int i = 0; i < NUM_DATA; i++) begin
            w_push[i] = w_accept & ((w_route == ROUTE_BCAST) ||
                        ((w_route == ROUTE_UNICAST) && (sel == SEL_W'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err_q <= 1'b0;
        end else begin
            r_sel_err_q <= w_sel_err_d;
        end
    end

    assign sel_err = r_sel_err_q;

    generate
        for (genvar g = 0; g < NUM_DATA; g++) begin : g_chan
            assign out_valid[g] = ~w_empty[g];
            assign w_pop[g]     = out_valid[g] & out_ready[g];

            demux_buf_fifo #(
                .DATA_BW (DATA_BW),
                .DEPTH   (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[g]),
                .i_pop   (w_pop[g]),
                .i_wdata (in_data),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g]),
                .o_count (out_count[g*CNT_W +: CNT_W]),
                .o_head  (out_data[g*DATA_BW +: DATA_BW])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_demux_buf.sv
// ============================================================================
// Module      : tb_demux_buf
// Description : Self-checking bench for demux_buf (3 channels, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_buf;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [1:0]        sel;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [DW*N-1:0]   out_data;
    logic [CW*N-1:0]   out_count;
    logic              sel_err;
`ifdef DEMUX_BCAST_EN
    logic              in_bcast;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_buf #(.NUM_DATA(N), .DATA_BW(DW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef DEMUX_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .sel_err   (sel_err)
    );

    // Reference model: every buffered word tagged with its channel, in arrival order
    typedef struct {
        int            ch;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    logic m_err  = 1'b0;
    logic m_init = 1'b0;

    function automatic int ch_size(input int c);
        int n = 0;
        foreach (mq[k]) if (mq[k].ch == c) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] ch_head(input int c);
        foreach (mq[k]) if (mq[k].ch == c) return mq[k].d;
        return '0;
    endfunction

    task automatic ch_pop(input int c);
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].ch == c) begin
                mq.delete(k);
                return;
            end
        end
    endtask

    function automatic logic model_ready();
        logic r;
`ifdef DEMUX_BCAST_EN
        if (in_bcast) begin
            r = 1'b1;
            for (int c = 0; c < N; c++) if (ch_size(c) >= D) r = 1'b0;
            return r;
        end
`endif
        if (int'(sel) >= N) r = 1'b1;
        else                r = (ch_size(int'(sel)) < D);
        return r;
    endfunction

    task automatic model_step();
        logic acc;
        logic bc;
        if (rst) begin
            mq.delete();
            m_err  = 1'b0;
            m_init = 1'b1;
            return;
        end
        acc = in_valid && model_ready();
        bc  = 1'b0;
`ifdef DEMUX_BCAST_EN
        bc = in_bcast;
`endif
        for (int c = 0; c < N; c++) begin
            if (out_ready[c] && ch_size(c) > 0) ch_pop(c);
        end
        m_err = 1'b0;
        if (acc) begin
            if (bc) begin
                for (int c = 0; c < N; c++) mq.push_back('{ch: c, d: in_data});
            end else if (int'(sel) < N) begin
                mq.push_back('{ch: int'(sel), d: in_data});
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: full output state against the model every cycle
    always @(negedge clk) begin
        logic [N-1:0]    ev;
        logic [DW*N-1:0] ed;
        logic [CW*N-1:0] ec;
        if (m_init) begin
            for (int c = 0; c < N; c++) begin
                ev[c]            = (ch_size(c) > 0);
                ed[c*DW +: DW]   = ch_head(c);
                ec[c*CW +: CW]   = CW'(ch_size(c));
            end
            chk("in_ready",  64'(in_ready),  64'(model_ready()));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("out_data",  64'(out_data),  64'(ed));
            chk("out_count", 64'(out_count), 64'(ec));
            chk("sel_err",   64'(sel_err),   64'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d);
        in_valid = v;
        sel      = s;
        in_data  = d;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = '0;
`ifdef DEMUX_BCAST_EN
        in_bcast  = 1'b0;
`endif
        drive(1'b1, 2'd0, 8'h77);

        // Reset with traffic offered
        repeat (2) cyc();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_count", 64'(out_count), 64'(0));
        chk("rst_err",   64'(sel_err),   64'(0));
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00);
        cyc();
        chk("post_rst_ready", 64'(in_ready), 64'(1));

        // Routing
        out_ready = 3'b111;
        drive(1'b1, 2'd0, 8'h11);
        cyc();
        chk("route0_valid", 64'(out_valid), 64'(3'b001));
        chk("route0_data",  64'(out_data[7:0]), 64'(8'h11));
        drive(1'b1, 2'd2, 8'h22);
        cyc();
        chk("route2_valid", 64'(out_valid), 64'(3'b100));
        chk("route2_data",  64'(out_data[23:16]), 64'(8'h22));
        drive(1'b0, 2'd0, 8'h00);
        cyc();

        // Full channel and order preservation
        out_ready = 3'b000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd1, 8'hA0 + 8'(k));
            cyc();
        end
        drive(1'b1, 2'd1, 8'hA4);
        #1;
        chk("full_count", 64'(out_count[5:3]), 64'(4));
        chk("full_ready", 64'(in_ready), 64'(0));
        chk("full_head",  64'(out_data[15:8]), 64'(8'hA0));
        cyc();
        out_ready = 3'b010;
        cyc();
        chk("pop1_head", 64'(out_data[15:8]), 64'(8'hA1));
        chk("pop1_ready", 64'(in_ready), 64'(1));
        cyc();
        drive(1'b0, 2'd0, 8'h00);
        chk("a4_acc_count", 64'(out_count[5:3]), 64'(3));
        for (int k = 2; k <= 4; k++) begin
            chk("order_head", 64'(out_data[15:8]), 64'(8'hA0 + 8'(k)));
            cyc();
        end
        chk("drained", 64'(out_valid), 64'(0));

        // Out-of-range select
        out_ready = 3'b111;
        drive(1'b1, 2'd3, 8'h99);
        #1;
        chk("oor_ready", 64'(in_ready), 64'(1));
        cyc();
        drive(1'b0, 2'd0, 8'h00);
        chk("oor_err",   64'(sel_err), 64'(1));
        chk("oor_count", 64'(out_count), 64'(0));
        cyc();
        chk("oor_err_clr", 64'(sel_err), 64'(0));

        // Channel independence
        out_ready = 3'b000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd0, 8'hC0 + 8'(k));
            cyc();
        end
        out_ready = 3'b100;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'd2, 8'h30 + 8'(k));
            #1;
            chk("stream_ready", 64'(in_ready), 64'(1));
            cyc();
            chk("stream_head", 64'(out_data[23:16]), 64'(8'h30 + 8'(k)));
        end
        drive(1'b0, 2'd0, 8'h00);
        chk("ch0_count", 64'(out_count[2:0]), 64'(4));
        chk("ch0_head",  64'(out_data[7:0]), 64'(8'hC0));
        out_ready = 3'b111;
        repeat (5) cyc();

`ifdef DEMUX_BCAST_EN
        in_bcast = 1'b1;
        drive(1'b1, 2'd0, 8'h5C);
        cyc();
        drive(1'b0, 2'd0, 8'h00);
        chk("bc_valid", 64'(out_valid), 64'(3'b111));
        chk("bc_data",  64'(out_data), 64'(24'h5C5C5C));
        cyc();
        in_bcast  = 1'b0;
        out_ready = 3'b000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd1, 8'hE0 + 8'(k));
            cyc();
        end
        in_bcast = 1'b1;
        drive(1'b1, 2'd0, 8'h6D);
        #1;
        chk("bc_full_ready", 64'(in_ready), 64'(0));
        cyc();
        chk("bc_full_counts", 64'(out_count), 64'({3'd0, 3'd4, 3'd0}));
        in_bcast = 1'b0;
        drive(1'b0, 2'd0, 8'h00);
        out_ready = 3'b111;
        repeat (5) cyc();
`endif

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 3'($urandom);
`ifdef DEMUX_BCAST_EN
            in_bcast  = ($urandom_range(0, 7) == 0);
`endif
            cyc();
        end
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
